// File: rtl/exe_stage_unit.sv
// exe_stage_unit -- execute stage, consumer side of the ID/EX register.
//
// Purpose:
//   The stage does four jobs:
//   - It forms the second operand (Val2). Val2 is one of three things: a
//     rotated 8-bit immediate, a shifted register, or a raw 12-bit memory
//     offset.
//   - It runs the 4-bit command ALU and holds the registered NZCV status.
//   - It computes the branch target.
//   - It executes MUL as a multi-cycle shift-add sequence. While that
//     sequence runs, stall_req holds the front of the pipeline.
//
// Ports:
//   clk, rst       clock (rising edge); synchronous active-high reset
//   flush          aborts an in-flight MUL and suppresses the status write
//   s_in           set-flags request
//   imm_in         selects the rotated-immediate form of Val2
//   mem_r_en_in    load: Val2 = offset, and the ALU is forced to ADD
//   mem_w_en_in    store: treated exactly like a load
//   exe_cmd_in     ALU command
//   pc_in          PC+4 of the instruction
//   val_rn_in      first operand
//   val_rm_in      register second operand
//   shift_op_in    12-bit shifter operand field
//   simm24_in      branch offset, counted in words
//   alu_result     ALU result; carries the product in the MUL DONE cycle
//   br_addr        pc_in + sext(simm24_in) * 4
//   status         registered {N,Z,C,V}
//   stall_req      held high while a MUL is incomplete
module exe_stage_unit #(
    parameter int MUL_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        s_in,
    input  logic        imm_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [11:0] shift_op_in,
    input  logic [23:0] simm24_in,
    output logic [31:0] alu_result,
    output logic [31:0] br_addr,
    output logic [3:0]  status,
    output logic        stall_req
);
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;
    localparam int CNT_W = $clog2(MUL_ITERS) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [31:0]        mcand, mplier, acc;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        val2, res;
    logic [32:0]        sum;
    logic [3:0]         cmd_eff;
    logic               c_f, v_f, flag_ok, mem_op, mul_start;

    // Rotate-right of the zero-extended 8-bit immediate by twice the 4-bit field.
    function automatic logic [31:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [31:0] b;
        logic [4:0]  r;
        b = {24'b0, imm8};
        r = {rot, 1'b0};
        if (r == 5'd0) return b;
        return (b >> r) | (b << (6'd32 - {1'b0, r}));
    endfunction

    // Register shifter; a zero amount passes the value through for every type.
    function automatic logic [31:0] shift_reg(input logic [31:0] v, input logic [4:0] amt,
                                              input logic [1:0] typ);
        logic signed [31:0] sv;
        sv = v;
        if (amt == 5'd0) return v;
        case (typ)
            2'b00:   return v << amt;
            2'b01:   return v >> amt;
            2'b10:   return sv >>> amt;
            default: return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
        endcase
    endfunction

    assign mem_op  = mem_r_en_in | mem_w_en_in;
    assign cmd_eff = mem_op ? CMD_ADD : exe_cmd_in;
    assign br_addr = pc_in + {{6{simm24_in[23]}}, simm24_in, 2'b00};

    always_comb begin
        if (mem_op)      val2 = {20'b0, shift_op_in};
        else if (imm_in) val2 = rot_imm(shift_op_in[7:0], shift_op_in[11:8]);
        else             val2 = shift_reg(val_rm_in, shift_op_in[11:7], shift_op_in[6:5]);
    end

    // Command ALU. The 33-bit sum carries C. Subtraction is computed as
    // Rn + ~Val2 + 1, so its carry out reads directly as "no borrow".
    always_comb begin
        res     = 32'd0;
        sum     = 33'd0;
        c_f     = status[1];
        v_f     = status[0];
        flag_ok = 1'b1;
        case (cmd_eff)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, val_rn_in} + {1'b0, val2}
                      + {32'b0, (cmd_eff == CMD_ADC) & status[1]};
                res = sum[31:0];
                c_f = sum[32];
                v_f = (val_rn_in[31] == val2[31]) & (res[31] != val_rn_in[31]);
            end
            CMD_SUB, CMD_SBC: begin
                sum = {1'b0, val_rn_in} + {1'b0, ~val2}
                      + ((cmd_eff == CMD_SUB) ? 33'd1 : {32'b0, status[1]});
                res = sum[31:0];
                c_f = sum[32];
                v_f = (val_rn_in[31] != val2[31]) & (res[31] != val_rn_in[31]);
            end
            CMD_AND: res = val_rn_in & val2;
            CMD_ORR: res = val_rn_in | val2;
            CMD_EOR: res = val_rn_in ^ val2;
            default: flag_ok = 1'b0;  // MUL and undefined codes leave the flags alone
        endcase
    end

    // The start cycle stalls combinationally, so the held MUL is latched
    // exactly once.
    assign mul_start  = (state == IDLE) && (cmd_eff == CMD_MUL) && !flush;
    assign stall_req  = mul_start || (state == BUSY);
    assign alu_result = (state == DONE) ? acc : res;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mul_start) state_nxt = BUSY;
            BUSY: begin
                if (flush)                                state_nxt = IDLE;
                else if (cnt == CNT_W'(MUL_ITERS - 1))    state_nxt = DONE;
            end
            default: state_nxt = IDLE;  // DONE never restarts the held MUL
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
            cnt    <= '0;
            status <= 4'd0;
        end else begin
            state <= state_nxt;
            if (mul_start) begin
                mcand  <= val_rn_in;
                mplier <= val2;
                acc    <= 32'd0;
                cnt    <= '0;
            end else if (state == BUSY && !flush) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            // A MUL with S updates only N and Z, and does so in its result
            // cycle.
            if (state == DONE) begin
                if (s_in && !flush && cmd_eff == CMD_MUL)
                    status <= {acc[31], acc == 32'd0, status[1:0]};
            end else if (s_in && !flush && !stall_req && flag_ok) begin
                status <= {res[31], res == 32'd0, c_f, v_f};
            end
        end
    end
endmodule

// File: tb/tb_exe_stage_unit.sv
// tb_exe_stage_unit -- scoreboard bench for exe_stage_unit. Each issued
// instruction pushes its expected result. The result is popped and compared
// when the DUT drops stall_req.
module tb_exe_stage_unit;
    logic        clk = 1'b0;
    logic        rst, flush, s_in, imm_in, mem_r_en_in, mem_w_en_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_op_in;
    logic [23:0] simm24_in;
    logic [31:0] alu_result, br_addr;
    logic [3:0]  status;
    logic        stall_req;

    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    exe_stage_unit #(.MUL_ITERS(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .s_in(s_in), .imm_in(imm_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .exe_cmd_in(exe_cmd_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_op_in(shift_op_in), .simm24_in(simm24_in), .alu_result(alu_result),
        .br_addr(br_addr), .status(status), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic imm, input logic mr, input logic mw,
                         input logic s, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] sop);
        exe_cmd_in = cmd; imm_in = imm; mem_r_en_in = mr; mem_w_en_in = mw;
        s_in = s; val_rn_in = rn; val_rm_in = rm; shift_op_in = sop;
    endtask

    // Issue one instruction at the next cycle. Then wait, bounded, for the
    // stall to drop, and compare both the result and the number of stalled
    // cycles.
    task automatic op(input string tag, input logic [3:0] cmd, input logic imm, input logic mr,
                      input logic mw, input logic s, input logic [31:0] rn, input logic [31:0] rm,
                      input logic [11:0] sop, input logic [31:0] exp, input int exp_stalls);
        int n;
        logic [31:0] e;
        @(posedge clk); #1;
        drive(cmd, imm, mr, mw, s, rn, rm, sop);
        exp_q.push_back(exp);
        n = 0;
        @(negedge clk);
        while (stall_req && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_stalls"}, n, exp_stalls);
        e = exp_q.pop_front();
        chk(tag, alu_result, e);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pc_in = 32'd0; simm24_in = 24'd0;
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 12'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_status", {28'd0, status}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        op("mov_imm_ror8", 4'b0001, 1, 0, 0, 0, 32'd0, 32'd0, 12'h4FF, 32'hFF000000, 0);
        op("sub_eq",       4'b0100, 0, 0, 0, 1, 32'd5, 32'd5, 12'h000, 32'd0, 0);
        op("add_ovf",      4'b0010, 1, 0, 0, 1, 32'h7FFFFFFF, 32'd0, 12'h001, 32'h80000000, 0);
        chk("status_zc", {28'd0, status}, 32'h6);
        op("sub_eq2",      4'b0100, 0, 0, 0, 1, 32'd5, 32'd5, 12'h000, 32'd0, 0);
        chk("status_nv", {28'd0, status}, 32'h9);
        op("adc_c1",       4'b0011, 1, 0, 0, 0, 32'd1, 32'd0, 12'h001, 32'd3, 0);
        chk("status_c", {28'd0, status}, 32'h6);
        op("sbc_c1",       4'b0101, 1, 0, 0, 0, 32'd10, 32'd0, 12'h003, 32'd7, 0);
        op("mov_asr4",     4'b0001, 0, 0, 0, 0, 32'd0, 32'h80000000, 12'h240, 32'hF8000000, 0);
        op("mov_asr0",     4'b0001, 0, 0, 0, 0, 32'd0, 32'h80000000, 12'h040, 32'h80000000, 0);
        op("mov_lsr31",    4'b0001, 0, 0, 0, 0, 32'd0, 32'h80000000, 12'hFA0, 32'd1, 0);
        op("mov_ror4",     4'b0001, 0, 0, 0, 0, 32'd0, 32'h12345678, 12'h260, 32'h81234567, 0);
        op("and",          4'b0110, 1, 0, 0, 0, 32'h0000F0F0, 32'd0, 12'h0FF, 32'h000000F0, 0);
        op("orr",          4'b0111, 1, 0, 0, 0, 32'h0000F000, 32'd0, 12'h00F, 32'h0000F00F, 0);
        op("eor",          4'b1000, 1, 0, 0, 0, 32'h000000FF, 32'd0, 12'h00F, 32'h000000F0, 0);
        op("mvn",          4'b1001, 1, 0, 0, 0, 32'd0, 32'd0, 12'h000, 32'hFFFFFFFF, 0);
        op("undef_cmd",    4'b0000, 1, 0, 0, 1, 32'd5, 32'd0, 12'h001, 32'd0, 0);

        // Multiply: 33 stalled cycles, then the product.
        op("mul_7x6",      4'b1010, 1, 0, 0, 0, 32'd7, 32'd0, 12'h006, 32'd42, 33);
        chk("status_undef_kept", {28'd0, status}, 32'h6);
        op("after_mul",    4'b0001, 1, 0, 0, 0, 32'd0, 32'd0, 12'h005, 32'd5, 0);
        op("mul_s_neg",    4'b1010, 1, 0, 0, 1, 32'hFFFFFFFF, 32'd0, 12'h001, 32'hFFFFFFFF, 33);

        // A MUL aborted by flush ten cycles in.
        @(posedge clk); #1;
        drive(4'b1010, 1, 0, 0, 1, 32'd3, 32'd0, 12'h005);
        @(negedge clk);
        chk("status_mul_nz", {28'd0, status}, 32'hA);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("flush_pre_stall", {31'd0, stall_req}, 32'd1);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drive(4'b0001, 1, 0, 0, 0, 32'd0, 32'd0, 12'h009);
        @(negedge clk);
        chk("flush_stall", {31'd0, stall_req}, 32'd0);
        chk("flush_res", alu_result, 32'd9);
        chk("flush_status", {28'd0, status}, 32'hA);
        op("mul_restart",  4'b1010, 1, 0, 0, 0, 32'd3, 32'd0, 12'h005, 32'd15, 33);

        // Memory ops force ADD even when the command field says MUL.
        op("ldr_addr",     4'b1010, 0, 1, 0, 0, 32'h200, 32'd0, 12'h010, 32'h210, 0);
        op("str_addr",     4'b0100, 0, 0, 1, 0, 32'h1000, 32'd0, 12'hFFF, 32'h1FFF, 0);

        pc_in = 32'h100; simm24_in = 24'hFFFFFE;
        #1 chk("br_back", br_addr, 32'hF8);
        pc_in = 32'hFFFFFFFC; simm24_in = 24'h000001;
        #1 chk("br_wrap", br_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
